instr_fetch_unit: RTL

// Fetch stage upstream of the main decoder. Owns the PC and issues word reads to

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus: imem read handshake, decoder-side instr, redirect
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr, op, pcplus4, instr_valid,
    input  imem_valid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, op, pcplus4, instr_valid,
    output imem_valid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem word reads, instruction register, redirects
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic        kill;
  logic [31:0] instr_q;
  logic [31:0] pcplus4_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] rpc;

  // Redirect targets are always word aligned; low two bits are dropped.
  assign rpc = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.pcplus4     = pcplus4_q;
  assign bus.instr_valid = valid_q;

  // Fetch FSM: owns pc, the kill flag for a stale outstanding read, and the instruction register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      tgt       <= 32'h0;
      kill      <= 1'b0;
      instr_q   <= 32'h0;
      pcplus4_q <= 32'h0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) pc <= rpc;
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (bus.imem_valid) begin
            if (kill || bus.redirect) begin
              // The returned word belongs to a path that was redirected away; refetch.
              pc   <= bus.redirect ? rpc : tgt;
              kill <= 1'b0;
            end else begin
              instr_q   <= bus.imem_rdata;
              pcplus4_q <= pc + 32'd4;
              state     <= HOLD;
              req_q     <= 1'b0;
              valid_q   <= 1'b1;
            end
          end else if (bus.redirect) begin
            // Request must stay stable until answered; remember where to go afterwards.
            kill <= 1'b1;
            tgt  <= rpc;
          end
        end
        HOLD: begin
          if (bus.redirect) begin
            pc      <= rpc;
            state   <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (bus.instr_ready) begin
            pc      <= pc + 32'd4;
            state   <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
